// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage registers.
// Imported by pipe_slot and pipe_stage_skid.
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam int OCC_W = 2;

   // Adds b to a, clamping at 2^w-1 (w <= 32).
   function automatic logic [31:0] sat_add(
      input logic [31:0] a,
      input logic [1:0]  b,
      input int unsigned w
   );
      logic [32:0] s;
      logic [32:0] m;
      m = (33'd1 << w) - 33'd1;
      s = {1'b0, a} + {31'd0, b};
      return (s > m) ? m[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + control + data, with load, clear and
// flush pass-through of the low data lane.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 48,
   parameter int PASS_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              pass,
   input  logic [CTRL_W-1:0] ld_ctrl,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [DATA_W-1:0] pass_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   localparam logic [DATA_W-1:0] PASS_MASK =
      ~({DATA_W{1'b1}} << PASS_W);

   // Cleared entries keep their data bits; only valid and ctrl drop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (pass) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= (data & ~PASS_MASK) | (pass_data & PASS_MASK);
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= ld_ctrl;
         data  <= ld_data;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional skid
// entry, flush with low-lane pass-through and a dropped-entry counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W       = 16,
   parameter int DATA_W       = 48,
   parameter int FLUSH_PASS_W = 8,
   parameter int SKID         = 1,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy,
   output logic [CNT_W-1:0]  drop_cnt
);

   logic              in_fire;
   logic              out_fire;
   logic              main_load;
   logic              main_clr;
   logic [CTRL_W-1:0] ld_ctrl;
   logic [DATA_W-1:0] ld_data;
   logic [1:0]        held;
   logic [CNT_W-1:0]  drop_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .PASS_W (FLUSH_PASS_W)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clear     (main_clr),
      .pass      (flush),
      .ld_ctrl   (ld_ctrl),
      .ld_data   (ld_data),
      .pass_data (in_data),
      .valid     (out_valid),
      .ctrl      (out_ctrl),
      .data      (out_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic [1:0]        state;
         logic [1:0]        state_nxt;
         logic              rdy_q;
         logic              skid_load;
         logic              skid_clr;
         logic              from_skid;
         logic              skid_valid;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [DATA_W-1:0] skid_data;

         pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W),
            .PASS_W (FLUSH_PASS_W)
         ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .load      (skid_load),
            .clear     (skid_clr | flush),
            .pass      (1'b0),
            .ld_ctrl   (in_ctrl),
            .ld_data   (in_data),
            .pass_data ('0),
            .valid     (skid_valid),
            .ctrl      (skid_ctrl),
            .data      (skid_data)
         );

         // in_ready is registered so out_ready never reaches it.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state <= ST_EMPTY;
               rdy_q <= 1'b1;
            end else begin
               state <= state_nxt;
               rdy_q <= (state_nxt != ST_FULL);
            end
         end

         always_comb begin
            state_nxt = state;
            if (flush) begin
               state_nxt = ST_EMPTY;
            end else begin
               unique case (state)
                  ST_EMPTY:
                     if (in_fire) state_nxt = ST_ONE;
                  ST_ONE:
                     if (in_fire & ~out_fire)
                        state_nxt = ST_FULL;
                     else if (out_fire & ~in_fire)
                        state_nxt = ST_EMPTY;
                  ST_FULL:
                     if (out_fire) state_nxt = ST_ONE;
                  default:
                     state_nxt = ST_EMPTY;
               endcase
            end
         end

         always_comb begin
            main_load = 1'b0;
            main_clr  = 1'b0;
            skid_load = 1'b0;
            skid_clr  = 1'b0;
            from_skid = 1'b0;
            unique case (state)
               ST_EMPTY: begin
                  main_load = in_fire;
               end
               ST_ONE: begin
                  main_load = in_fire & out_fire;
                  skid_load = in_fire & ~out_fire;
                  main_clr  = out_fire & ~in_fire;
               end
               ST_FULL: begin
                  main_load = out_fire;
                  from_skid = out_fire;
                  skid_clr  = out_fire;
               end
               default: ;
            endcase
         end

         assign ld_ctrl   = from_skid ? skid_ctrl : in_ctrl;
         assign ld_data   = from_skid ? skid_data : in_data;
         assign in_ready  = rdy_q;
         assign occupancy = state;
         assign held      = 2'(out_valid & ~out_fire)
                          + 2'(skid_valid);
      end else begin : g_single
         assign in_ready  = out_ready | ~out_valid;
         assign main_load = in_fire;
         assign main_clr  = out_fire & ~in_fire;
         assign ld_ctrl   = in_ctrl;
         assign ld_data   = in_data;
         assign occupancy = {1'b0, out_valid};
         assign held      = {1'b0, out_valid & ~out_fire};
      end
   endgenerate

   // Only entries already held and not delivered count as dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         drop_q <= '0;
      else if (flush)
         drop_q <= CNT_W'(sat_add(32'(drop_q), held, CNT_W));
   end

   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid and single-entry builds driven with
// shared stimulus and compared every cycle against a queue model.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] in_ctrl;
   logic [47:0] in_data;

   logic        in_ready_a, out_valid_a;
   logic [15:0] out_ctrl_a;
   logic [47:0] out_data_a;
   logic [1:0]  occ_a;
   logic [1:0]  drop_a;

   logic        in_ready_b, out_valid_b;
   logic [15:0] out_ctrl_b;
   logic [47:0] out_data_b;
   logic [1:0]  occ_b;
   logic [7:0]  drop_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .CTRL_W(16), .DATA_W(48), .FLUSH_PASS_W(8),
      .SKID(1), .CNT_W(2)
   ) u_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_ctrl(out_ctrl_a), .out_data(out_data_a),
      .occupancy(occ_a), .drop_cnt(drop_a)
   );

   pipe_stage_skid #(
      .CTRL_W(16), .DATA_W(48), .FLUSH_PASS_W(8),
      .SKID(0), .CNT_W(8)
   ) u_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_ctrl(out_ctrl_b), .out_data(out_data_b),
      .occupancy(occ_b), .drop_cnt(drop_b)
   );

   // FIFO of up to cap entries plus the last head data seen downstream.
   typedef struct {
      int               n;
      logic [1:0][15:0] c;
      logic [1:0][47:0] d;
      logic [47:0]      od;
      int               drops;
   } model_t;

   model_t ma, mb;

   function automatic model_t mclear();
      model_t m;
      m.n = 0;
      m.c = '0;
      m.d = '0;
      m.od = '0;
      m.drops = 0;
      return m;
   endfunction

   function automatic bit rdy(model_t m, int cap);
      if (cap == 2) return m.n < 2;
      return out_ready || (m.n == 0);
   endfunction

   function automatic model_t step(model_t m, int cap, int maxd);
      model_t r;
      bit inf, outf;
      r = m;
      inf = in_valid && rdy(m, cap);
      outf = out_ready && (m.n > 0);
      if (flush) begin
         r.drops = m.drops + m.n - (outf ? 1 : 0);
         if (r.drops > maxd) r.drops = maxd;
         r.n = 0;
         r.c = '0;
         r.od[7:0] = in_data[7:0];
      end else begin
         if (outf) begin
            r.c[0] = r.c[1];
            r.d[0] = r.d[1];
            r.n = r.n - 1;
         end
         if (inf) begin
            r.c[r.n[0]] = in_ctrl;
            r.d[r.n[0]] = in_data;
            r.n = r.n + 1;
         end
         if (r.n > 0) r.od = r.d[0];
      end
      return r;
   endfunction

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_models();
      chk("a_in_ready", 64'(in_ready_a), 64'(rdy(ma, 2)));
      chk("a_out_valid", 64'(out_valid_a), 64'(ma.n > 0));
      chk("a_out_ctrl", 64'(out_ctrl_a),
          64'(ma.n > 0 ? ma.c[0] : 16'h0));
      chk("a_out_data", 64'(out_data_a), 64'(ma.od));
      chk("a_occupancy", 64'(occ_a), 64'(ma.n));
      chk("a_drop_cnt", 64'(drop_a), 64'(ma.drops));
      chk("b_in_ready", 64'(in_ready_b), 64'(rdy(mb, 1)));
      chk("b_out_valid", 64'(out_valid_b), 64'(mb.n > 0));
      chk("b_out_ctrl", 64'(out_ctrl_b),
          64'(mb.n > 0 ? mb.c[0] : 16'h0));
      chk("b_out_data", 64'(out_data_b), 64'(mb.od));
      chk("b_occupancy", 64'(occ_b), 64'(mb.n));
      chk("b_drop_cnt", 64'(drop_b), 64'(mb.drops));
   endtask

   // Check at negedge, advance models at posedge, return at posedge+1.
   task automatic tick();
      @(negedge clk);
      check_models();
      @(posedge clk);
      ma = step(ma, 2, 3);
      mb = step(mb, 1, 255);
      #1;
   endtask

   task automatic drive(input bit f, input bit iv, input bit orr,
                        input logic [15:0] c, input logic [47:0] d);
      flush = f;
      in_valid = iv;
      out_ready = orr;
      in_ctrl = c;
      in_data = d;
   endtask

   function automatic logic [47:0] rdata();
      return 48'({$urandom(), $urandom()});
   endfunction

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 16'h0, 48'h0);
      ma = mclear();
      mb = mclear();
      #12;
      chk("rst_a_valid", 64'(out_valid_a), 64'd0);
      chk("rst_a_ready", 64'(in_ready_a), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("init_a_occ", 64'(occ_a), 64'd0);
      chk("init_a_drop", 64'(drop_a), 64'd0);

      // Streaming at full rate
      for (int k = 1; k <= 4; k++) begin
         drive(0, 1, 1, 16'(k), rdata());
         tick();
         chk("stream_ctrl", 64'(out_ctrl_a), 64'(k));
         chk("stream_occ", 64'(occ_a), 64'd1);
         chk("stream_ready", 64'(in_ready_a), 64'd1);
      end
      drive(0, 0, 1, 16'h0, rdata());
      tick();

      // Backpressure fills skid, then drains in order
      drive(0, 1, 0, 16'h000A, rdata());
      tick();
      drive(0, 1, 0, 16'h000B, rdata());
      tick();
      chk("bp_occ_full", 64'(occ_a), 64'd2);
      chk("bp_ready_low", 64'(in_ready_a), 64'd0);
      chk("bp_head_a", 64'(out_ctrl_a), 64'h000A);
      drive(0, 1, 0, 16'h000C, rdata());
      tick();
      chk("bp_c_held", 64'(out_ctrl_a), 64'h000A);
      drive(0, 1, 1, 16'h000C, in_data);
      tick();
      chk("bp_head_b", 64'(out_ctrl_a), 64'h000B);
      tick();
      chk("bp_head_c", 64'(out_ctrl_a), 64'h000C);
      drive(0, 0, 1, 16'h0, rdata());
      tick();
      chk("bp_drained", 64'(occ_a), 64'd0);

      // Flush while full
      drive(0, 1, 0, 16'h0011, rdata());
      tick();
      drive(0, 1, 0, 16'h0012, rdata());
      tick();
      drive(1, 1, 0, 16'h0013, 48'hABCD_EF01_233C);
      tick();
      chk("fl_valid", 64'(out_valid_a), 64'd0);
      chk("fl_ctrl", 64'(out_ctrl_a), 64'd0);
      chk("fl_data_lo", 64'(out_data_a[7:0]), 64'h3C);
      chk("fl_occ", 64'(occ_a), 64'd0);
      chk("fl_drop", 64'(drop_a), 64'd2);
      chk("fl_ready", 64'(in_ready_a), 64'd1);

      // Flush with concurrent in_fire and out_fire
      drive(0, 1, 0, 16'h0021, rdata());
      tick();
      drive(1, 1, 1, 16'h0022, rdata());
      tick();
      chk("flc_drop", 64'(drop_a), 64'd2);
      chk("flc_occ", 64'(occ_a), 64'd0);

      // Saturation of the 2-bit counter
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 0, 16'h0031, rdata());
         tick();
         tick();
         drive(1, 0, 0, 16'h0, rdata());
         tick();
         chk("sat_drop", 64'(drop_a), 64'd3);
      end

      // Single-entry build: combinational in_ready
      drive(0, 1, 0, 16'h0041, rdata());
      tick();
      chk("nsk_valid", 64'(out_valid_b), 64'd1);
      chk("nsk_ready_lo", 64'(in_ready_b), 64'd0);
      out_ready = 1'b1;
      #1;
      chk("nsk_ready_hi", 64'(in_ready_b), 64'd1);
      drive(0, 0, 1, 16'h0, rdata());
      tick();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 19) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0,
               16'($urandom()), rdata());
         tick();
      end

      // Asynchronous reset in the middle of traffic
      drive(0, 1, 0, 16'h0051, rdata());
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("ar_a_valid", 64'(out_valid_a), 64'd0);
      chk("ar_a_ctrl", 64'(out_ctrl_a), 64'd0);
      chk("ar_a_data", 64'(out_data_a), 64'd0);
      chk("ar_a_occ", 64'(occ_a), 64'd0);
      chk("ar_a_drop", 64'(drop_a), 64'd0);
      chk("ar_a_ready", 64'(in_ready_a), 64'd1);
      chk("ar_b_valid", 64'(out_valid_b), 64'd0);
      chk("ar_b_data", 64'(out_data_b), 64'd0);
      chk("ar_b_drop", 64'(drop_b), 64'd0);
      ma = mclear();
      mb = mclear();
      drive(0, 0, 0, 16'h0, 48'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 15) == 0,
               $urandom_range(0, 1) != 0,
               $urandom_range(0, 3) != 0,
               16'($urandom()), rdata());
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline-stage register for the 8-bit core.
- Successor to the fixed per-stage control/data latches (ID/EX style).
- Adds a valid/ready handshake with an optional 2-entry skid buffer, flush with partial data pass-through, bubble forcing on control, occupancy output and a dropped-entry counter.
- Sits between any two pipeline stages.

Parameters:
- CTRL_W, 16: control-bundle width; cleared on flush, reset and bubble.
- DATA_W, 48: data-bundle width (operands, register addresses, immediate, PC+1, IP).
- FLUSH_PASS_W, 8: low bits of data still captured from in_data on flush (PC+1 lane); 0..DATA_W.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 8: width of the dropped-entry counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; transfer when in_valid&in_ready.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts; transfer when out_valid&out_ready.
- out_ctrl  out  CTRL_W  head control; all-zero whenever out_valid=0.
- out_data  out  DATA_W  head data.
- occupancy  out  2  entries held: 0, 1, or 2 (2 only if SKID=1).
- drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Reset (rst=0, async):
  - out_valid=0, out_ctrl=0, out_data=0, skid entry cleared, occupancy=0, drop_cnt=0.
  - in_ready=1 (SKID=1); SKID=0 in_ready follows the combinational rule below.
  - A reset mid-transfer discards everything; no partial state survives.
- Fire signals: in_fire=in_valid&in_ready; out_fire=out_valid&out_ready.
- SKID=1 states are EMPTY (occ 0), ONE (occ 1), FULL (occ 2); in_ready is registered, =1 in EMPTY/ONE and 0 in FULL.
  - EMPTY: in_fire -> main<=in, ONE. Otherwise stay.
  - ONE: in_fire&out_fire -> main<=in, ONE. in_fire only -> skid<=in, FULL. out_fire only -> main cleared, EMPTY. Neither -> hold.
  - FULL: out_fire -> main<=skid, skid cleared, ONE. Else hold. in_fire impossible.
  - Latency is 1 cycle: an entry accepted at edge N is on out_* after edge N.
  - No combinational path from out_ready to in_ready.
  - Order is strictly FIFO.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - in_fire -> main<=in. out_fire&~in_fire -> main cleared.
  - occupancy is 0 or 1.
- Bubble rule: any cleared entry has valid=0 and ctrl=0, so downstream decodes a NOP. Data bits of a cleared entry hold their last value.
- Flush (synchronous, highest priority after reset):
  - All entries invalidated and ctrl zeroed; state -> EMPTY; in_ready=1 on the next cycle.
  - main data[FLUSH_PASS_W-1:0] <= in_data[FLUSH_PASS_W-1:0] regardless of in_valid; upper data bits hold.
  - Any in_fire on the flush cycle is discarded. Any out_fire on the flush cycle still counts as delivered downstream.
  - drop_cnt += number of valid entries held and not out_fired on that edge (0..2), saturating at 2^CNT_W-1. Incoming entries are not counted.
- No overflow is possible: in_ready=0 in FULL. in_valid while in_ready=0 is ignored, with no state change.

Decomposition:
- Shared package pipe_pkg: state localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; an occupancy-width constant; a helper function for saturating add.
- One natural sub-module, pipe_slot: valid+ctrl+data register with load, clear and pass-through-on-flush controls. It is instantiated as main and skid; when SKID=0 the skid instance is not generated.

Test Plan:
- Reset then stream (SKID=1, out_ready=1): in_valid=1 for 4 cycles with ctrl=0x0001..0x0004 -> out_ctrl 0x0001..0x0004 one cycle later each; occupancy stays 1; in_ready=1 throughout.
- Backpressure: out_ready=0, push A, B -> occupancy 2, in_ready=0, out_ctrl=A; C held. Raise out_ready -> A, B, C emerge in order, no loss or duplication.
- Flush when FULL: flush=1, in_data low byte=0x3C -> next cycle out_valid=0, out_ctrl=0, out_data[7:0]=0x3C, occupancy=0, drop_cnt=2, in_ready=1.
- Flush concurrent with in_fire and out_fire (occ 1): the incoming entry is dropped, the head is delivered, and drop_cnt is unchanged.
- drop_cnt saturation with CNT_W=2: 3 flushes of a FULL stage -> drop_cnt=3, not wrapping.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Assert rst low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
